pipe_ctrl: RTL and testbench

Pipeline control unit for the 16-bit five-stage CPU. It sits directly upstream of the datapath: it decodes the Decode-stage opcode into the per-instruction control word (`branchC`, `flushC`, `RegWriteC`, `MemWriteC`, `MemToRegC`, `immediateC`, `alufuncC`). It also owns the global pipeline `enable` and runs a small FSM that inserts load-use stalls, branch-flush bubbles and halt.

---
 rtl/cpu_pkg.sv | 27 ++
 rtl/ctrl_decode.sv | 48 ++++
 rtl/pipe_ctrl.sv | 114 +++++++++++
 tb/tb_pipe_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcodes, ALU codes, pipeline FSM states and control word
package cpu_pkg;
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_ADDI = 4'h4;
  localparam logic [3:0] OP_LD   = 4'h5;
  localparam logic [3:0] OP_ST   = 4'h6;
  localparam logic [3:0] OP_BR   = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;
  typedef enum logic [2:0] {IDLE, RUN, STALL, FLUSH, HALT} pipeState;
  typedef struct packed {
    logic       branch;
    logic       flush;
    logic       regWrite;
    logic       memWrite;
    logic       memToReg;
    logic       immediate;
    logic [1:0] aluFunc;
  } ctrlWord;
  localparam int CTRL_W = $bits(ctrlWord);
endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational opcode to control word and source-register usage
module ctrl_decode
  import cpu_pkg::*;
(
  input  logic [3:0]        opcode,
  output logic [CTRL_W-1:0] ctrl,
  output logic              readsRs1,
  output logic              readsRs2
);
  ctrlWord word;
  // opcode table; unknown opcodes decode as NOP
  always_comb begin
    word = '0;
    readsRs1 = 1'b0;
    readsRs2 = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        word.regWrite = 1'b1;
        word.aluFunc = opcode[1:0];
        readsRs1 = 1'b1;
        readsRs2 = 1'b1;
      end
      OP_ADDI: begin
        word.regWrite = 1'b1;
        word.immediate = 1'b1;
        word.aluFunc = ALU_ADD;
        readsRs1 = 1'b1;
      end
      OP_LD: begin
        word.regWrite = 1'b1;
        word.memToReg = 1'b1;
        word.immediate = 1'b1;
        word.aluFunc = ALU_ADD;
        readsRs1 = 1'b1;
      end
      OP_ST: begin
        word.memWrite = 1'b1;
        word.immediate = 1'b1;
        word.aluFunc = ALU_ADD;
        readsRs1 = 1'b1;
        readsRs2 = 1'b1;
      end
      OP_BR: word.branch = 1'b1;
      default: word = '0;
    endcase
  end
  assign ctrl = word;
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline control FSM (stall/flush/halt); PIPE_CTRL_PERF_EN adds stall_cnt/flush_cnt
module pipe_ctrl
  import cpu_pkg::*;
#(
  parameter int STALL_CYCLES = 2,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] opcodeD,
  input  logic [3:0] rs1D,
  input  logic [3:0] rs2D,
  input  logic [3:0] rdE,
  input  logic       MemToRegE,
  output logic       enable,
  output logic       branchC,
  output logic       flushC,
  output logic       RegWriteC,
  output logic       MemWriteC,
  output logic       MemToRegC,
  output logic       immediateC,
  output logic [1:0] alufuncC,
  output logic       halted
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
`endif
);
  localparam logic [2:0] STALL_LOAD = 3'(STALL_CYCLES - 1);
  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);
  pipeState state, nextState;
  logic [2:0] cnt, nextCnt;
  logic [CTRL_W-1:0] decoded;
  ctrlWord dec, ctrl;
  logic readsRs1, readsRs2, hazard;
  ctrl_decode uDecode (
    .opcode  (opcodeD),
    .ctrl    (decoded),
    .readsRs1(readsRs1),
    .readsRs2(readsRs2)
  );
  assign dec = decoded;
  assign hazard = MemToRegE && rdE != 4'd0 &&
                  ((readsRs1 && rdE == rs1D) || (readsRs2 && rdE == rs2D));
  // state and bubble counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= 3'd0;
    end else begin
      state <= nextState;
      cnt <= nextCnt;
    end
  end
  // next state and per-state enable / control word; the detect cycle is the first lost cycle
  always_comb begin
    nextState = state;
    nextCnt = cnt;
    ctrl = '0;
    enable = 1'b0;
    halted = 1'b0;
    case (state)
      IDLE: nextState = start ? RUN : IDLE;
      RUN: begin
        if (hazard) begin
          nextState = STALL_CYCLES > 1 ? STALL : RUN;
          nextCnt = STALL_LOAD;
        end else if (opcodeD == OP_HALT) begin
          nextState = HALT;
        end else begin
          enable = 1'b1;
          ctrl = dec;
          nextState = dec.branch ? FLUSH : RUN;
          nextCnt = dec.branch ? FLUSH_LOAD : cnt;
        end
      end
      STALL: begin
        nextState = cnt <= 3'd1 ? RUN : STALL;
        nextCnt = cnt - 3'd1;
      end
      FLUSH: begin
        enable = 1'b1;
        ctrl.flush = 1'b1;
        nextState = cnt == 3'd1 ? RUN : FLUSH;
        nextCnt = cnt - 3'd1;
      end
      HALT: halted = 1'b1;
      default: nextState = IDLE;
    endcase
  end
  assign branchC = ctrl.branch;
  assign flushC = ctrl.flush;
  assign RegWriteC = ctrl.regWrite;
  assign MemWriteC = ctrl.memWrite;
  assign MemToRegC = ctrl.memToReg;
  assign immediateC = ctrl.immediate;
  assign alufuncC = ctrl.aluFunc;
`ifdef PIPE_CTRL_PERF_EN
  // saturating stall and flush cycle counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= 16'd0;
      flush_cnt <= 16'd0;
    end else begin
      if (((state == RUN && hazard) || state == STALL) && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
      if (state == FLUSH && flush_cnt != 16'hFFFF)
        flush_cnt <= flush_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: vector table, corner sequences and random run against a reference model
module tb_pipe_ctrl;
  logic clk = 1'b0;
  logic reset, start, MemToRegE;
  logic [3:0] opcodeD, rs1D, rs2D, rdE;
  logic enA, brA, flA, rwA, mwA, mtrA, immA, haltA;
  logic enB, brB, flB, rwB, mwB, mtrB, immB, haltB;
  logic [1:0] aluA, aluB;
  logic [9:0] gotA, gotB, lastB;
  int total = 0;
  int bad = 0;
  int started[2], stopped[2], stallLeft[2], flushLeft[2], perfStall[2], perfFlush[2];
`ifdef PIPE_CTRL_PERF_EN
  logic [15:0] scA, fcA, scB, fcB;
`endif

  always #5 clk = ~clk;

  pipe_ctrl #(.STALL_CYCLES(2), .FLUSH_CYCLES(1)) dutA (
    .clk(clk), .reset(reset), .start(start), .opcodeD(opcodeD), .rs1D(rs1D), .rs2D(rs2D),
    .rdE(rdE), .MemToRegE(MemToRegE), .enable(enA), .branchC(brA), .flushC(flA),
    .RegWriteC(rwA), .MemWriteC(mwA), .MemToRegC(mtrA), .immediateC(immA),
    .alufuncC(aluA), .halted(haltA)
`ifdef PIPE_CTRL_PERF_EN
    , .stall_cnt(scA), .flush_cnt(fcA)
`endif
  );

  pipe_ctrl #(.STALL_CYCLES(1), .FLUSH_CYCLES(3)) dutB (
    .clk(clk), .reset(reset), .start(start), .opcodeD(opcodeD), .rs1D(rs1D), .rs2D(rs2D),
    .rdE(rdE), .MemToRegE(MemToRegE), .enable(enB), .branchC(brB), .flushC(flB),
    .RegWriteC(rwB), .MemWriteC(mwB), .MemToRegC(mtrB), .immediateC(immB),
    .alufuncC(aluB), .halted(haltB)
`ifdef PIPE_CTRL_PERF_EN
    , .stall_cnt(scB), .flush_cnt(fcB)
`endif
  );

  assign gotA = {enA, brA, flA, rwA, mwA, mtrA, immA, aluA, haltA};
  assign gotB = {enB, brB, flB, rwB, mwB, mtrB, immB, aluB, haltB};

  typedef struct {
    logic       st;
    logic [3:0] op, r1, r2, rd;
    logic       mte;
    logic [9:0] exp;
  } vec_t;
  vec_t tab[19];

  function automatic vec_t mk(input logic st, input logic [3:0] op, r1, r2, rd,
                              input logic mte, input logic [9:0] e);
    vec_t v;
    v.st = st; v.op = op; v.r1 = r1; v.r2 = r2; v.rd = rd; v.mte = mte; v.exp = e;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  // issued control word {enable,branch,flush,regWrite,memWrite,memToReg,imm,alu,halted}
  function automatic logic [9:0] issueWord(input logic [3:0] op);
    logic [1:0] f;
    f = op[1:0];
    if (op <= 4'd3) return {7'b1001000, f, 1'b0};
    if (op == 4'd4) return 10'b1001001000;
    if (op == 4'd5) return 10'b1001011000;
    if (op == 4'd6) return 10'b1000101000;
    if (op == 4'd8) return 10'b1100000000;
    return 10'b1000000000;
  endfunction

  task automatic model(input int i, output logic [9:0] e);
    int s, f;
    logic r1, r2;
    s = (i == 0) ? 2 : 1;
    f = (i == 0) ? 1 : 3;
    r1 = opcodeD <= 4'd6;
    r2 = opcodeD <= 4'd3 || opcodeD == 4'd6;
    e = 10'b0;
    if (started[i] == 0) begin
      if (start) started[i] = 1;
    end else if (stopped[i] != 0) begin
      e = 10'b0000000001;
    end else if (stallLeft[i] > 0) begin
      stallLeft[i]--;
      perfStall[i]++;
    end else if (flushLeft[i] > 0) begin
      e = 10'b1010000000;
      flushLeft[i]--;
      perfFlush[i]++;
    end else if (MemToRegE && rdE != 0 && ((r1 && rdE == rs1D) || (r2 && rdE == rs2D))) begin
      stallLeft[i] = s - 1;
      perfStall[i]++;
    end else if (opcodeD == 4'hF) begin
      stopped[i] = 1;
    end else begin
      e = issueWord(opcodeD);
      if (opcodeD == 4'd8) flushLeft[i] = f;
    end
  endtask

  task automatic clearModel();
    for (int i = 0; i < 2; i++) begin
      started[i] = 0; stopped[i] = 0; stallLeft[i] = 0;
      flushLeft[i] = 0; perfStall[i] = 0; perfFlush[i] = 0;
    end
  endtask

  task automatic step(input logic st, input logic [3:0] op, r1, r2, rd, input logic mte,
                      input string nm, input logic useTab, input logic [9:0] tabExp);
    logic [9:0] ea, eb;
    start = st; opcodeD = op; rs1D = r1; rs2D = r2; rdE = rd; MemToRegE = mte;
    @(negedge clk);
`ifdef PIPE_CTRL_PERF_EN
    chk({nm, " stall_cnt A"}, scA, 16'(perfStall[0]));
    chk({nm, " flush_cnt A"}, fcA, 16'(perfFlush[0]));
    chk({nm, " stall_cnt B"}, scB, 16'(perfStall[1]));
    chk({nm, " flush_cnt B"}, fcB, 16'(perfFlush[1]));
`endif
    model(0, ea);
    model(1, eb);
    lastB = gotB;
    if (useTab) chk({nm, " table A"}, 16'(gotA), 16'(tabExp));
    chk({nm, " model A"}, 16'(gotA), 16'(ea));
    chk({nm, " model B"}, 16'(gotB), 16'(eb));
    @(posedge clk);
    #1;
  endtask

  task automatic doReset(input string nm);
    #1;
    reset = 1'b1;
    #1;
    chk({nm, " async A"}, 16'(gotA), 16'd0);
    chk({nm, " async B"}, 16'(gotB), 16'd0);
    clearModel();
    @(negedge clk);
    chk({nm, " held A"}, 16'(gotA), 16'd0);
    chk({nm, " held B"}, 16'(gotB), 16'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int fl;
    logic [3:0] op;
    reset = 1'b1; start = 1'b0; opcodeD = 4'd0; rs1D = 4'd0; rs2D = 4'd0;
    rdE = 4'd0; MemToRegE = 1'b0; lastB = 10'd0;
    clearModel();
    doReset("power-on");
    tab[0]  = mk(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 10'b0000000000);
    tab[1]  = mk(1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 10'b0000000000);
    tab[2]  = mk(1'b0, 4'd0, 4'd1, 4'd2, 4'd0, 1'b0, 10'b1001000000);
    tab[3]  = mk(1'b0, 4'd1, 4'd1, 4'd3, 4'd3, 1'b1, 10'b0000000000);
    tab[4]  = mk(1'b0, 4'd1, 4'd1, 4'd3, 4'd3, 1'b1, 10'b0000000000);
    tab[5]  = mk(1'b0, 4'd1, 4'd1, 4'd3, 4'd3, 1'b0, 10'b1001000010);
    tab[6]  = mk(1'b0, 4'd1, 4'd1, 4'd3, 4'd0, 1'b1, 10'b1001000010);
    tab[7]  = mk(1'b0, 4'd2, 4'd4, 4'd5, 4'd6, 1'b1, 10'b1001000100);
    tab[8]  = mk(1'b0, 4'd4, 4'd1, 4'd6, 4'd6, 1'b1, 10'b1001001000);
    tab[9]  = mk(1'b0, 4'd6, 4'd1, 4'd6, 4'd6, 1'b1, 10'b0000000000);
    tab[10] = mk(1'b0, 4'd6, 4'd1, 4'd6, 4'd6, 1'b0, 10'b0000000000);
    tab[11] = mk(1'b0, 4'd6, 4'd1, 4'd6, 4'd6, 1'b0, 10'b1000101000);
    tab[12] = mk(1'b0, 4'd5, 4'd2, 4'd0, 4'd6, 1'b0, 10'b1001011000);
    tab[13] = mk(1'b0, 4'd8, 4'd0, 4'd0, 4'd0, 1'b0, 10'b1100000000);
    tab[14] = mk(1'b0, 4'd3, 4'd1, 4'd2, 4'd0, 1'b0, 10'b1010000000);
    tab[15] = mk(1'b0, 4'd3, 4'd1, 4'd2, 4'd0, 1'b0, 10'b1001000110);
    tab[16] = mk(1'b0, 4'd7, 4'd1, 4'd2, 4'd0, 1'b0, 10'b1000000000);
    tab[17] = mk(1'b0, 4'hF, 4'd0, 4'd0, 4'd0, 1'b0, 10'b0000000000);
    tab[18] = mk(1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 10'b0000000001);
    foreach (tab[i])
      step(tab[i].st, tab[i].op, tab[i].r1, tab[i].r2, tab[i].rd, tab[i].mte,
           $sformatf("vec%0d", i), 1'b1, tab[i].exp);
    for (int i = 0; i < 20; i++)
      step(1'b1, 4'(i), 4'd1, 4'd1, 4'd1, 1'b1, "halt hold", 1'b1, 10'b0000000001);
    doReset("leave halt");
    step(1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, "restart", 1'b1, 10'b0000000000);
    step(1'b0, 4'd3, 4'd2, 4'd2, 4'd2, 1'b1, "stall enter", 1'b1, 10'b0000000000);
    doReset("mid stall");
    step(1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, "restart2", 1'b1, 10'b0000000000);
    step(1'b0, 4'd8, 4'd0, 4'd0, 4'd0, 1'b0, "branch", 1'b1, 10'b1100000000);
    fl = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, "after branch", 1'b0, 10'b0);
      fl += int'(lastB[7]);
    end
    chk("flush3 count B", 16'(fl), 16'd3);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 79) == 0) doReset("rand reset");
      op = 4'($urandom_range(0, 15));
      if (op == 4'hF && $urandom_range(0, 9) != 0) op = 4'd0;
      step(1'($urandom_range(0, 1)), op, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
           4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), "rand", 1'b0, 10'b0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
